// File: rtl/turn_controller_if.sv
// rtl/turn_controller_if.sv - move/board/status bundle between switch inputs, board register and turn_controller
interface turn_controller_if;
   logic        submit;
   logic        clear;
   logic [3:0]  sel;
   logic [17:0] board;
   logic [4:0]  move;
   logic        player;
   logic [1:0]  win;
   logic        draw;
   logic        illegal;
   logic        timeout;

   modport master (
      output submit, clear, sel, board,
      input  move, player, win, draw, illegal, timeout
   );

   modport slave (
      input  submit, clear, sel, board,
      output move, player, win, draw, illegal, timeout
   );
endinterface

// File: rtl/turn_controller.sv
// rtl/turn_controller.sv - tic-tac-toe turn sequencer; optional forfeit timer under TURN_TIMEOUT_EN
module turn_controller #(
   parameter logic [4:0]  IDLE_CODE      = 5'b01111,
   parameter logic        FIRST_PLAYER   = 1'b0,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
) (
   input logic clk,
   input logic reset_n,
   turn_controller_if.slave bus
);

   typedef enum logic [2:0] {S_CLEAR, S_WAIT, S_ISSUE, S_SETTLE, S_OVER} state_t;

   state_t     state;
   logic [4:0] move_q;
   logic       player_q;
   logic [1:0] win_q;
   logic       draw_q;
   logic       illegal_q;
   logic       pending;

   logic [8:0] free;
   logic [8:0] mine;
   logic [1:0] pcode;
   logic       sel_ok;
   logic       go_clear;
   logic       accept;
   logic       line_done;

   always_comb begin
      free  = '0;
      mine  = '0;
      pcode = player_q ? 2'b10 : 2'b01;
      for (int k = 0; k < 9; k++) begin
         free[k] = (bus.board[2*k +: 2] == 2'b00);
         mine[k] = (bus.board[2*k +: 2] == pcode);
      end
      sel_ok    = (bus.sel != 4'd0) && (bus.sel <= 4'd9) && free[bus.sel - 4'd1];
      go_clear  = bus.clear || pending;
      accept    = bus.submit && sel_ok;
      line_done = (mine[0] & mine[1] & mine[2]) | (mine[3] & mine[4] & mine[5]) |
                  (mine[6] & mine[7] & mine[8]) | (mine[0] & mine[3] & mine[6]) |
                  (mine[1] & mine[4] & mine[7]) | (mine[2] & mine[5] & mine[8]) |
                  (mine[0] & mine[4] & mine[8]) | (mine[2] & mine[4] & mine[6]);
   end

`ifdef TURN_TIMEOUT_EN
   logic [31:0] count;
   logic        timeout_q;
   logic        timeout_hit;

   assign timeout_hit = (state == S_WAIT) && !go_clear && !accept &&
                        (count == TIMEOUT_CYCLES - 32'd1);

   // Counter only advances while waiting for a move; any other state holds it at zero.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count     <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         if (state != S_WAIT || go_clear || accept) begin
            count <= '0;
         end else if (timeout_hit) begin
            count     <= '0;
            timeout_q <= 1'b1;
         end else begin
            count <= count + 32'd1;
         end
      end
   end

   assign bus.timeout = timeout_q;
`else
   logic unused_timeout_cycles;
   assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
   assign bus.timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= S_CLEAR;
         move_q    <= IDLE_CODE;
         player_q  <= FIRST_PLAYER;
         win_q     <= 2'b00;
         draw_q    <= 1'b0;
         illegal_q <= 1'b0;
         pending   <= 1'b0;
      end else begin
         illegal_q <= 1'b0;
         case (state)
            // Entered from reset move is still IDLE_CODE, so spend one cycle driving the clear code.
            S_CLEAR: begin
               if (bus.clear) pending <= 1'b1;
               if (move_q != 5'b00000) begin
                  move_q <= 5'b00000;
               end else begin
                  move_q   <= IDLE_CODE;
                  player_q <= FIRST_PLAYER;
                  win_q    <= 2'b00;
                  draw_q   <= 1'b0;
                  state    <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (go_clear) begin
                  move_q  <= 5'b00000;
                  pending <= 1'b0;
                  state   <= S_CLEAR;
               end else if (accept) begin
                  move_q <= {player_q, bus.sel};
                  state  <= S_ISSUE;
               end else begin
                  if (bus.submit) illegal_q <= 1'b1;
`ifdef TURN_TIMEOUT_EN
                  if (timeout_hit) player_q <= ~player_q;
`endif
               end
            end
            S_ISSUE: begin
               if (bus.clear) pending <= 1'b1;
               move_q <= IDLE_CODE;
               state  <= S_SETTLE;
            end
            S_SETTLE: begin
               if (bus.clear) pending <= 1'b1;
               if (line_done) begin
                  win_q <= {player_q, ~player_q};
                  state <= S_OVER;
               end else if (free == 9'd0) begin
                  draw_q <= 1'b1;
                  state  <= S_OVER;
               end else begin
                  player_q <= ~player_q;
                  state    <= S_WAIT;
               end
            end
            S_OVER: begin
               if (go_clear) begin
                  move_q  <= 5'b00000;
                  pending <= 1'b0;
                  state   <= S_CLEAR;
               end
            end
            default: state <= S_CLEAR;
         endcase
      end
   end

   assign bus.move    = move_q;
   assign bus.player  = player_q;
   assign bus.win     = win_q;
   assign bus.draw    = draw_q;
   assign bus.illegal = illegal_q;

endmodule
